// File: rtl/apb_arb_master.sv
// ---------------------------------------------------------------------------
// apb_arb_master
//   Two-requester round-robin arbiter in front of a single APB master port.
//   Each requester posts a transfer; the winner's fields are captured into the
//   APB payload registers and the transfer runs IDLE -> SETUP -> ACCESS.
//   Completion is reported to the owning requester with a one-cycle pulse.
//
// Handshake (requester side):
//   A requester raises REQ_VALID[i] with its fields stable and keeps them
//   stable until it sees REQ_ACK[i]. REQ_ACK[i] is registered and is high for
//   exactly the SETUP cycle of the transfer whose fields were captured at the
//   preceding edge. RSP_VALID[i] pulses for one cycle after the APB access
//   completes; RSP_RDATA / RSP_ERR are valid with it and hold otherwise. A
//   requester may see RSP_VALID for one transfer and REQ_ACK for another in
//   the same cycle.
//
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH, PROT_WIDTH  payload widths (SW = DATA_WIDTH/8)
//   TIMEOUT_CYCLES                      ACCESS wait limit (timeout build only)
//
// Configuration macro:
//   APB_ARB_TIMEOUT_EN  when defined, an ACCESS phase with PREADY low for
//                       TIMEOUT_CYCLES cycles ends with RSP_ERR=1, RSP_RDATA=0.
//                       When undefined, ACCESS waits for PREADY forever.
//
// Ports:
//   PCLK, PRESETn                clock, async active-low reset
//   REQ_VALID/WRITE/ADDR/WDATA/STRB/PROT   packed requester inputs (slice i)
//   REQ_ACK, RSP_VALID           one-hot per requester
//   RSP_RDATA, RSP_ERR           shared response payload
//   PSEL..PPROT                  APB master outputs
//   PREADY, PSLVERR, PRDATA      APB slave response
//   fsm_state                    debug view of the FSM (0 IDLE, 1 SETUP, 2 ACCESS)
// ---------------------------------------------------------------------------
module apb_arb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PROT_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SW            = DATA_WIDTH / 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              REQ_VALID,
  input  logic [1:0]              REQ_WRITE,
  input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [2*SW-1:0]         REQ_STRB,
  input  logic [2*PROT_WIDTH-1:0] REQ_PROT,
  output logic [1:0]              REQ_ACK,
  output logic [1:0]              RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic                    RSP_ERR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [SW-1:0]           PSTRB,
  output logic [PROT_WIDTH-1:0]   PPROT,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  output logic [1:0]              fsm_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state, state_nx;

  // Reset is applied asynchronously but released through two flops so the
  // first edge the logic acts on already sees a clean IDLE state.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  logic win;         // requester chosen this cycle
  logic prio;        // requester that wins a tie (the one not granted last)
  logic owner;       // requester owning the transfer on the bus
  logic grant;       // capture winner's fields at this edge
  logic done;        // current ACCESS phase ends at this edge
  logic timeout_hit;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle with PREADY low.
  assign timeout_hit = (state == ST_ACCESS) && !PREADY &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n)                                        to_cnt <= '0;
    else if (state == ST_SETUP)                        to_cnt <= '0;
    else if ((state == ST_ACCESS) && !PREADY && !timeout_hit) to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    win      = prio;
    done     = 1'b0;
    grant    = 1'b0;
    state_nx = state;

    if (REQ_VALID == 2'b01)      win = 1'b0;
    else if (REQ_VALID == 2'b10) win = 1'b1;

    done  = (state == ST_ACCESS) && (PREADY || timeout_hit);
    // Arbitration happens from IDLE and also on the completing ACCESS edge,
    // which gives back-to-back transfers without an IDLE gap.
    grant = (REQ_VALID != 2'b00) && ((state == ST_IDLE) || done);

    case (state)
      ST_IDLE:   if (grant) state_nx = ST_SETUP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (done) state_nx = grant ? ST_SETUP : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  assign PSEL      = (state != ST_IDLE);
  assign PENABLE   = (state == ST_ACCESS);
  assign fsm_state = state;

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      owner     <= 1'b0;
      REQ_ACK   <= 2'b00;
      RSP_VALID <= 2'b00;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= '0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
    end else begin
      REQ_ACK   <= grant ? (win ? 2'b10 : 2'b01) : 2'b00;
      RSP_VALID <= done ? (owner ? 2'b10 : 2'b01) : 2'b00;

      if (done) begin
        // PREADY takes precedence; otherwise the end was caused by timeout.
        RSP_ERR   <= PREADY ? PSLVERR : 1'b1;
        RSP_RDATA <= (PREADY && !PWRITE) ? PRDATA : '0;
      end

      if (grant) begin
        owner  <= win;
        prio   <= ~win;
        PWRITE <= REQ_WRITE[win];
        PADDR  <= win ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
        PWDATA <= win ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
        PPROT  <= win ? REQ_PROT[2*PROT_WIDTH-1:PROT_WIDTH] : REQ_PROT[PROT_WIDTH-1:0];
        // Reads never carry strobes.
        if (REQ_WRITE[win]) PSTRB <= win ? REQ_STRB[2*SW-1:SW] : REQ_STRB[SW-1:0];
        else                PSTRB <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
module tb_apb_arb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = 3;
  localparam int SW = DW / 8;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [1:0]      REQ_VALID, REQ_WRITE;
  logic [2*AW-1:0] REQ_ADDR;
  logic [2*DW-1:0] REQ_WDATA;
  logic [2*SW-1:0] REQ_STRB;
  logic [2*PW-1:0] REQ_PROT;
  logic [1:0]      REQ_ACK, RSP_VALID;
  logic [DW-1:0]   RSP_RDATA;
  logic            RSP_ERR;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [SW-1:0]   PSTRB;
  logic [PW-1:0]   PPROT;
  logic            PREADY, PSLVERR;
  logic [DW-1:0]   PRDATA;
  logic [1:0]      fsm_state;

  apb_arb_master dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB), .REQ_PROT(REQ_PROT),
    .REQ_ACK(REQ_ACK), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Outputs are sampled 1 time unit after the rising edge; inputs are changed
  // right after sampling, well before the next edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic [PW-1:0] p);
    REQ_WRITE[i]          = w;
    REQ_ADDR[i*AW +: AW]  = a;
    REQ_WDATA[i*DW +: DW] = d;
    REQ_STRB[i*SW +: SW]  = s;
    REQ_PROT[i*PW +: PW]  = p;
  endtask

  int own_seq[4] = '{1, 0, 1, 0};
  int prev_own;
  int pen_cnt;
  int wait_cnt;

  initial begin
    PRESETn = 1'b0; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    REQ_STRB = '0; REQ_PROT = '0; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = '0;

    // ---- reset state ----
    repeat (2) tick();
    check("rst_state",  fsm_state, 0);
    check("rst_psel",   {PSEL, PENABLE, PWRITE}, 0);
    check("rst_ack_rsp", {REQ_ACK, RSP_VALID, RSP_ERR}, 0);
    check("rst_payload", {PADDR, PWDATA}, 0);
    check("rst_strb_prot", {PSTRB, PPROT}, 0);
    check("rst_rdata",  RSP_RDATA, 0);
    PRESETn = 1'b1;
    repeat (3) tick();

    // ---- single write, requester 0 ----
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
    REQ_VALID = 2'b01;
    tick();
    check("wr_setup_state", fsm_state, 1);
    check("wr_setup_ctl", {PSEL, PENABLE, PWRITE}, 3'b101);
    check("wr_setup_ack", REQ_ACK, 2'b01);
    check("wr_paddr", PADDR, 32'h10);
    check("wr_pwdata", PWDATA, 32'hDEADBEEF);
    check("wr_pstrb_pprot", {PSTRB, PPROT}, {4'hF, 3'b010});
    REQ_VALID = 2'b00;
    tick();
    check("wr_access_ctl", {PSEL, PENABLE}, 2'b11);
    check("wr_access_ack", REQ_ACK, 2'b00);
    check("wr_access_hold", {PADDR, PWDATA}, {32'h10, 32'hDEADBEEF});
    tick();
    check("wr_rsp_valid", RSP_VALID, 2'b01);
    check("wr_rsp_err", RSP_ERR, 0);
    check("wr_rsp_rdata", RSP_RDATA, 0);
    check("wr_idle_psel", PSEL, 0);
    tick();
    check("wr_rsp_pulse", RSP_VALID, 2'b00);

    // ---- contention: both requesting; 0 was granted last so 1 goes first ----
    set_req(0, 1'b0, 32'h100, 32'h0, 4'hF, 3'b000);
    set_req(1, 1'b1, 32'h200, 32'hCAFE0001, 4'h3, 3'b001);
    PRDATA = 32'hA5A50000;
    REQ_VALID = 2'b11;
    prev_own = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("cont_ack", REQ_ACK, (own_seq[k] == 1) ? 2'b10 : 2'b01);
      check("cont_setup_ctl", {PSEL, PENABLE}, 2'b10);
      check("cont_paddr", PADDR, (own_seq[k] == 1) ? 32'h200 : 32'h100);
      check("cont_pstrb", PSTRB, (own_seq[k] == 1) ? 4'h3 : 4'h0);
      if (k > 0) begin
        check("cont_rsp_with_ack", RSP_VALID, (prev_own == 1) ? 2'b10 : 2'b01);
        check("cont_rsp_rdata", RSP_RDATA, exp_q.pop_front());
      end
      if (k == 3) REQ_VALID = 2'b00;
      tick();
      check("cont_access_ctl", {PSEL, PENABLE}, 2'b11);
      exp_q.push_back((own_seq[k] == 1) ? 32'h0 : 32'hA5A50000);
      prev_own = own_seq[k];
    end
    tick();
    check("cont_last_rsp", RSP_VALID, 2'b01);
    check("cont_last_rdata", RSP_RDATA, exp_q.pop_front());
    check("cont_idle", PSEL, 0);

    // ---- wait states on a read from requester 1 ----
    set_req(1, 1'b0, 32'h44, 32'h0, 4'hF, 3'b000);
    PREADY = 1'b0; PRDATA = 32'h0;
    REQ_VALID = 2'b10;
    tick();
    check("ws_ack", REQ_ACK, 2'b10);
    check("ws_setup_pstrb", PSTRB, 0);
    REQ_VALID = 2'b00;
    pen_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (PENABLE) pen_cnt++;
      check("ws_pstrb", PSTRB, 0);
      check("ws_no_rsp", RSP_VALID, 0);
      if (i == 3) begin
        PREADY = 1'b1;
        PRDATA = 32'h12345678;
      end
    end
    check("ws_penable_cycles", pen_cnt, 4);
    tick();
    check("ws_rsp_valid", RSP_VALID, 2'b10);
    check("ws_rsp_rdata", RSP_RDATA, 32'h12345678);
    check("ws_rsp_err", RSP_ERR, 0);
    check("ws_penable_low", PENABLE, 0);
    PRDATA = 32'h0;
    tick();
    check("ws_rdata_hold", {RSP_VALID, RSP_RDATA}, {2'b00, 32'h12345678});

    // ---- slave error on a write from requester 0 ----
    set_req(0, 1'b1, 32'h80, 32'h11, 4'hF, 3'b000);
    PSLVERR = 1'b1;
    REQ_VALID = 2'b01;
    tick();
    check("err_ack", REQ_ACK, 2'b01);
    REQ_VALID = 2'b00;
    tick();
    tick();
    check("err_rsp_owner", RSP_VALID, 2'b01);
    check("err_rsp_err", RSP_ERR, 1);
    check("err_rsp_rdata", RSP_RDATA, 0);
    PSLVERR = 1'b0;
    tick();
    check("err_hold", {RSP_VALID, RSP_ERR}, {2'b00, 1'b1});

    // ---- reset during ACCESS ----
    set_req(1, 1'b1, 32'h300, 32'h5, 4'h1, 3'b000);
    PREADY = 1'b0;
    REQ_VALID = 2'b10;
    tick();
    check("rstm_ack", REQ_ACK, 2'b10);
    REQ_VALID = 2'b00;
    tick();
    check("rstm_access", PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    check("rstm_async_ctl", {PSEL, PENABLE}, 2'b00);
    check("rstm_async_state", fsm_state, 0);
    PREADY = 1'b1;
    tick();
    check("rstm_no_rsp", RSP_VALID, 0);
    PRESETn = 1'b1;
    set_req(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000);
    set_req(1, 1'b0, 32'h404, 32'h0, 4'h0, 3'b000);
    PRDATA = 32'h5A5A1234;
    REQ_VALID = 2'b11;
    wait_cnt = 0;
    while (REQ_ACK == 2'b00 && wait_cnt < 10) begin
      tick();
      wait_cnt++;
      check("rstm_no_rsp_wait", RSP_VALID, 0);
    end
    check("rstm_ack_seen", (REQ_ACK != 2'b00), 1);
    check("rstm_tie_to_0", REQ_ACK, 2'b01);
    check("rstm_paddr", PADDR, 32'h400);
    REQ_VALID = 2'b00;
    tick();
    tick();
    check("rstm_rsp", RSP_VALID, 2'b01);
    check("rstm_rdata", RSP_RDATA, 32'h5A5A1234);

    // ---- PREADY stuck low ----
    set_req(1, 1'b0, 32'h500, 32'h0, 4'h0, 3'b000);
    PRDATA = 32'h77778888;
    PREADY = 1'b0;
    REQ_VALID = 2'b10;
    tick();
    check("to_ack", REQ_ACK, 2'b10);
    REQ_VALID = 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
    pen_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (PENABLE && RSP_VALID == 2'b00) pen_cnt++;
    end
    check("to_access_cycles", pen_cnt, 16);
    tick();
    check("to_rsp_valid", RSP_VALID, 2'b10);
    check("to_rsp_err", RSP_ERR, 1);
    check("to_rsp_rdata", RSP_RDATA, 0);
    check("to_idle", PSEL, 0);
`else
    repeat (100) tick();
    check("nto_still_access", fsm_state, 2);
    check("nto_penable", PENABLE, 1);
    check("nto_no_rsp", RSP_VALID, 0);
    PREADY = 1'b1;
    tick();
    check("nto_rsp_valid", RSP_VALID, 2'b10);
    check("nto_rsp_rdata", RSP_RDATA, 32'h77778888);
    check("nto_rsp_err", RSP_ERR, 0);
`endif
    tick();

    // ---- report ----
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
